// File: rtl/watch_ctrl_pkg.sv
// Shared encodings and limits for the watch time-setting controller.
// Alarm states exist only when WATCH_CTRL_ALARM_EN is defined.
package watch_ctrl_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

`ifdef WATCH_CTRL_ALARM_EN
  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_SET_AH = 3'd4,
    ST_SET_AM = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/watch_ctrl_wrapinc.sv
// Combinational increment with wrap to zero once the value reaches max.
// Zero latency; no flow control.
module watch_ctrl_wrapinc #(
  parameter int W = 6
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] max,
  output logic [W-1:0] value_inc
);

  // >= also folds any out-of-range load back into the legal range
  assign value_inc = (value >= max) ? '0 : value + W'(1);

endmodule

// File: rtl/watch_ctrl.sv
// Time-setting FSM for a watch: edits shadow copies of h/m/s and loads them back with a one-cycle ld.
// Single-cycle response to button pulses; no backpressure. Optional alarm via WATCH_CTRL_ALARM_EN.
module watch_ctrl
  import watch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic              cancel_btn,
`ifdef WATCH_CTRL_ALARM_EN
  input  logic              alarm_btn,
  output logic              alarm,
  output logic              alarm_on,
`endif
  input  logic [HOUR_W-1:0] hour_cur,
  input  logic [MIN_W-1:0]  min_cur,
  input  logic [SEC_W-1:0]  sec_cur,
  output logic              ld,
  output logic [HOUR_W-1:0] hour_in,
  output logic [MIN_W-1:0]  min_in,
  output logic [SEC_W-1:0]  sec_in,
  output logic              ci,
  output logic [1:0]        field
);

  state_t            state, state_nxt;
  logic              ld_nxt;
  logic [HOUR_W-1:0] sh_h, sh_h_nxt, sh_h_inc;
  logic [MIN_W-1:0]  sh_m, sh_m_nxt, sh_m_inc;
  logic [SEC_W-1:0]  sh_s, sh_s_nxt, sh_s_inc;

  watch_ctrl_wrapinc #(.W(HOUR_W)) u_inc_h (.value(sh_h), .max(HOUR_MAX), .value_inc(sh_h_inc));
  watch_ctrl_wrapinc #(.W(MIN_W))  u_inc_m (.value(sh_m), .max(MIN_MAX),  .value_inc(sh_m_inc));
  watch_ctrl_wrapinc #(.W(SEC_W))  u_inc_s (.value(sh_s), .max(SEC_MAX),  .value_inc(sh_s_inc));

`ifdef WATCH_CTRL_ALARM_EN
  // Alarm is edited in scratch registers so a cancel leaves the stored alarm intact
  logic [HOUR_W-1:0] alarm_h, alarm_h_nxt, edit_ah, edit_ah_nxt, edit_ah_inc;
  logic [MIN_W-1:0]  alarm_m, alarm_m_nxt, edit_am, edit_am_nxt, edit_am_inc;
  logic              alarm_on_nxt;

  watch_ctrl_wrapinc #(.W(HOUR_W)) u_inc_ah (.value(edit_ah), .max(HOUR_MAX), .value_inc(edit_ah_inc));
  watch_ctrl_wrapinc #(.W(MIN_W))  u_inc_am (.value(edit_am), .max(MIN_MAX),  .value_inc(edit_am_inc));

  assign alarm = alarm_on && (hour_cur == alarm_h) && (min_cur == alarm_m);
`endif

  always_comb begin
    state_nxt = state;
    ld_nxt    = 1'b0;
    sh_h_nxt  = sh_h;
    sh_m_nxt  = sh_m;
    sh_s_nxt  = sh_s;
    field     = FIELD_NONE;
`ifdef WATCH_CTRL_ALARM_EN
    alarm_h_nxt  = alarm_h;
    alarm_m_nxt  = alarm_m;
    edit_ah_nxt  = edit_ah;
    edit_am_nxt  = edit_am;
    alarm_on_nxt = alarm_on;
`endif
    case (state)
      ST_RUN: begin
        if (mode_btn) begin
          state_nxt = ST_SET_H;
          sh_h_nxt  = hour_cur;
          sh_m_nxt  = min_cur;
          sh_s_nxt  = sec_cur;
        end
`ifdef WATCH_CTRL_ALARM_EN
        else if (alarm_btn) begin
          if (alarm) begin
            alarm_on_nxt = 1'b0;
          end else begin
            state_nxt   = ST_SET_AH;
            edit_ah_nxt = alarm_h;
            edit_am_nxt = alarm_m;
          end
        end
`endif
      end
      ST_SET_H: begin
        field = FIELD_HOUR;
        if (cancel_btn)    state_nxt = ST_RUN;
        else if (mode_btn) state_nxt = ST_SET_M;
        else if (inc_btn)  sh_h_nxt  = sh_h_inc;
      end
      ST_SET_M: begin
        field = FIELD_MIN;
        if (cancel_btn)    state_nxt = ST_RUN;
        else if (mode_btn) state_nxt = ST_SET_S;
        else if (inc_btn)  sh_m_nxt  = sh_m_inc;
      end
      ST_SET_S: begin
        field = FIELD_SEC;
        if (cancel_btn) begin
          state_nxt = ST_RUN;
        end else if (mode_btn) begin
          state_nxt = ST_RUN;
          ld_nxt    = 1'b1;
        end else if (inc_btn) begin
          sh_s_nxt = sh_s_inc;
        end
      end
`ifdef WATCH_CTRL_ALARM_EN
      ST_SET_AH: begin
        field = FIELD_HOUR;
        if (cancel_btn)    state_nxt   = ST_RUN;
        else if (mode_btn) state_nxt   = ST_SET_AM;
        else if (inc_btn)  edit_ah_nxt = edit_ah_inc;
      end
      ST_SET_AM: begin
        field = FIELD_MIN;
        if (cancel_btn) begin
          state_nxt = ST_RUN;
        end else if (mode_btn) begin
          state_nxt    = ST_RUN;
          alarm_h_nxt  = edit_ah;
          alarm_m_nxt  = edit_am;
          alarm_on_nxt = 1'b1;
        end else if (inc_btn) begin
          edit_am_nxt = edit_am_inc;
        end
      end
`endif
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      ld    <= 1'b0;
      sh_h  <= '0;
      sh_m  <= '0;
      sh_s  <= '0;
`ifdef WATCH_CTRL_ALARM_EN
      alarm_h  <= '0;
      alarm_m  <= '0;
      edit_ah  <= '0;
      edit_am  <= '0;
      alarm_on <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ld    <= ld_nxt;
      sh_h  <= sh_h_nxt;
      sh_m  <= sh_m_nxt;
      sh_s  <= sh_s_nxt;
`ifdef WATCH_CTRL_ALARM_EN
      alarm_h  <= alarm_h_nxt;
      alarm_m  <= alarm_m_nxt;
      edit_ah  <= edit_ah_nxt;
      edit_am  <= edit_am_nxt;
      alarm_on <= alarm_on_nxt;
`endif
    end
  end

  // The load cycle itself is frozen too, so a tick landing there is lost
  assign ci      = tick && (state == ST_RUN) && !ld;
  assign hour_in = sh_h;
  assign min_in  = sh_m;
  assign sec_in  = sh_s;

endmodule
